// File: rtl/segdecode_spi_host.sv
// rtl/segdecode_spi_host.sv - SPI host sweeping four digit/keypad frames to the segment-decoder peripheral
module segdecode_spi_host #(
    parameter int CLK_DIV = 2,
    parameter int GAP     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [15:0] digits,
    input  logic        dev_rst,
    input  logic        spi_miso,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        spi_en,
    output logic        spi_rst_n,
    output logic [3:0]  keys,
    output logic        keys_valid
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_TAIL  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = $clog2(GAP + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [GW-1:0] GAP_LD   = GW'(GAP);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    logic [1:0]    r_state;
    logic [DW-1:0] r_div;
    logic [2:0]    r_bit;
    logic [GW-1:0] r_gap;
    logic [1:0]    r_idx;
    logic [7:0]    r_shreg;
    logic          r_sck;
    logic          r_mosi;
    logic          r_en;
    logic          r_rst_n;
    logic [3:0]    r_keys;
    logic          r_kv_pend;
    logic          r_kv;
    logic          r_miso_s1;
    logic          r_miso_s2;

    logic [1:0]    w_idx_next;
    logic [3:0]    w_digit;
    logic [7:0]    w_byte;
    logic          w_gap_done;

    // A frame launched from GAP belongs to the following index; from IDLE the index is already current.
    assign w_idx_next = (r_state == S_GAP) ? r_idx + 2'd1 : r_idx;
    assign w_digit    = digits[{w_idx_next, 2'b00} +: 4];
    assign w_byte     = {w_idx_next, w_idx_next, w_digit};
    assign w_gap_done = (r_gap <= GAP_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_bit     <= '0;
            r_gap     <= GAP_LD;
            r_idx     <= '0;
            r_shreg   <= '0;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
            r_en      <= 1'b0;
            r_rst_n   <= 1'b0;
            r_keys    <= '0;
            r_kv_pend <= 1'b0;
            r_kv      <= 1'b0;
            r_miso_s1 <= 1'b0;
            r_miso_s2 <= 1'b0;
        end else begin
            r_rst_n   <= ~dev_rst;
            r_miso_s1 <= spi_miso;
            r_miso_s2 <= r_miso_s1;
            r_kv      <= r_kv_pend;
            r_kv_pend <= 1'b0;
            if (dev_rst) begin
                r_state <= S_IDLE;
                r_en    <= 1'b0;
                r_sck   <= 1'b0;
                r_mosi  <= 1'b0;
                r_idx   <= '0;
                r_gap   <= GAP_LD;
                r_kv    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_gap_done) begin
                            r_gap <= r_gap - GAP_ONE;
                        end else if (run) begin
                            r_state <= S_SHIFT;
                            r_en    <= 1'b1;
                            r_sck   <= 1'b0;
                            r_mosi  <= w_byte[7];
                            r_shreg <= w_byte;
                            r_div   <= '0;
                            r_bit   <= '0;
                        end
                    end
                    S_SHIFT: begin
                        if (r_div == DIV_LAST) begin
                            r_div <= '0;
                            if (!r_sck) begin
                                r_sck <= 1'b1;
                            end else begin
                                r_sck <= 1'b0;
                                if (r_bit == 3'd7) begin
                                    r_state <= S_TAIL;
                                end else begin
                                    r_bit   <= r_bit + 3'd1;
                                    r_mosi  <= r_shreg[6];
                                    r_shreg <= {r_shreg[6:0], 1'b0};
                                end
                            end
                        end else begin
                            r_div <= r_div + DIV_ONE;
                        end
                    end
                    S_TAIL: begin
                        if (r_div == DIV_LAST) begin
                            r_div   <= '0;
                            r_en    <= 1'b0;
                            r_mosi  <= 1'b0;
                            r_gap   <= GAP_LD;
                            r_state <= S_GAP;
                        end else begin
                            r_div <= r_div + DIV_ONE;
                        end
                    end
                    default: begin
                        if (!w_gap_done) begin
                            r_gap <= r_gap - GAP_ONE;
                        end else begin
                            // Peripheral has settled on the byte just latched; keys are active-low on MISO.
                            r_keys[r_idx] <= ~r_miso_s2;
                            r_idx         <= r_idx + 2'd1;
                            if (r_idx == 2'd3) begin
                                r_kv_pend <= 1'b1;
                            end
                            if (run) begin
                                r_state <= S_SHIFT;
                                r_en    <= 1'b1;
                                r_sck   <= 1'b0;
                                r_mosi  <= w_byte[7];
                                r_shreg <= w_byte;
                                r_div   <= '0;
                                r_bit   <= '0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign spi_sck    = r_sck;
    assign spi_mosi   = r_mosi;
    assign spi_en     = r_en;
    assign spi_rst_n  = r_rst_n;
    assign keys       = r_keys;
    assign keys_valid = r_kv;

endmodule

// File: doc/segdecode_spi_host.md
# segdecode_spi_host

Clocked SPI host that drives the segment-decoder/keypad peripheral over its 4-wire bus (SCK, MOSI, EN, RESET) and reads back its MISO line. It runs a continuous four-frame sweep: each frame writes one hex digit and selects one display and one keypad column, then samples the addressed keypad column. The block sits in the controller die beside the peripheral and replaces the bit-banged driver.

## Interface
Parameters:
- CLK_DIV, 2: clk cycles per SCK half-period; legal ≥1.
- GAP, 8: EN-low clk cycles between frames; legal ≥3, which covers MISO sync and settle.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  1 = sweep continuously; 0 = finish current frame, then idle.
- digits  in  16  four hex digits; digits[4n+3:4n] is shown on screen n.
- dev_rst  in  1  level request to hold the peripheral in reset.
- spi_miso  in  1  peripheral MISO; asynchronous to clk; 2-FF synchronised.
- spi_sck  out  1  SPI clock; peripheral samples MOSI on rising edge.
- spi_mosi  out  1  serial data, MSB first.
- spi_en  out  1  frame enable, active high; falling edge latches the byte in the peripheral.
- spi_rst_n  out  1  peripheral RESET, active low.
- keys  out  4  debounce-free key column states; keys[n] = ~MISO sampled after frame n.
- keys_valid  out  1  one-cycle pulse after frame 3's sample (full sweep).

## Operation
- Frame byte for index n (0..3): {n[1:0] keypad column, n[1:0] screen select, digit n}. The digit is snapshotted from `digits` in the cycle before EN rises.
- Frame index wraps 3→0. The index advances only after a completed frame.
- FSM states:
  - IDLE: spi_en=0, spi_sck=0. Go to SHIFT when run=1, dev_rst=0, and the gap counter has expired.
  - SHIFT: 8 bits, each D=CLK_DIV cycles with SCK low, then D cycles with SCK high. MOSI updates at the start of each low phase.
  - TAIL: D cycles with SCK=0 and EN=1.
  - GAP: EN=0 for GAP cycles. On the last GAP cycle, the synchronised MISO is captured into keys[n]. Then go to SHIFT if run=1, else IDLE.
- keys_valid pulses in the cycle after keys[3] updates.
- The peripheral presents the selected column combinationally from its latched byte. The sample in GAP therefore reflects the byte just written.
- dev_rst=1: spi_rst_n=0 next cycle. Any frame in progress is aborted: EN, SCK and MOSI go to 0 immediately (registered, next cycle). The state goes to IDLE and the frame index resets to 0. keys is held and no keys_valid is issued. On release, spi_rst_n=1 next cycle, then a full GAP passes before the next frame.
- run falling mid-frame has no effect until the frame's GAP completes and its sample is taken.
- Async rst_n low forces outputs to their reset values immediately, mid-frame included:
  - spi_sck=0, spi_mosi=0, spi_en=0, spi_rst_n=0, keys=0, keys_valid=0.
  - frame index=0, state=IDLE, gap counter loaded with GAP.
- After reset is released, spi_rst_n rises on the first clk edge (unless dev_rst=1).

## Timing
- Cycle 0 is the first cycle with spi_en=1.
- Bit k (k=0 is the MSB):
  - SCK low on cycles [2kD, 2kD+D-1].
  - SCK high on cycles [2kD+D, 2kD+2D-1].
- Tail: cycles [16D, 17D-1], with SCK=0 and EN=1.
- spi_en falls at cycle 17D. The MISO sample uses the sync output at cycle 17D+GAP-1. keys updates at cycle 17D+GAP.
- Continuous frame period is 17D+GAP cycles, so a sweep takes 4·(17D+GAP). Defaults give 42 cycles per frame and 168 per sweep.
- MOSI is stable for ≥D cycles on both sides of each SCK rising edge.
- EN falls with SCK low. SCK never toggles while EN=0.
- First frame after reset starts GAP cycles after rst_n deassertion, provided run=1.

## Test plan
- Byte stream: CLK_DIV=2, GAP=8, digits=16'h3A5C, run=1 → a behavioural peripheral model latches 0x0C, 0x55, 0xAA, 0xF3, 0x0C… Frame period is 42 cycles and EN-high is 34 cycles.
- Key readback: model columns=4'b0101 → after one sweep keys=4'b0101 and keys_valid pulses once. Changing to 4'b1000 gives keys=4'b1000 after the next sweep, with exactly one pulse per 168 cycles.
- Minimum timing: CLK_DIV=1, GAP=3 → frame period is 20 cycles. The model still latches the correct bytes, and no SCK edge coincides with a MOSI change.
- run drop mid-frame: run=0 at cycle 5 of frame 1 → frame 1 completes and keys[1] updates. No further EN pulses occur, and keys_valid does not fire.
- dev_rst at cycle 10 of frame 2 → spi_rst_n=0, and EN/SCK/MOSI are 0 the next cycle. After release, the first byte is frame 0 (0x0C), and keys is unchanged throughout.
- Async reset mid-shift: rst_n low at cycle 7 → all outputs go to their reset values without a clk edge. The sequence restarts at frame 0 GAP cycles after release.
